// File: rtl/reg_select_bank.sv
// reg_select_bank: EIP/EBP/ESP/GPR register bank with stack and fetch updates
// and two registered operand read ports (code 0 = immediate path, reads zero).
module reg_select_bank #(
    parameter int                 DATA_W     = 32,
    parameter int                 OUT_W      = 8,
    parameter int                 SEL_W      = 4,
    parameter int                 NUM_GPR    = 4,
    parameter int                 STACK_STEP = 4,
    parameter logic [DATA_W-1:0]  ESP_RESET  = 'h100,
    parameter logic [DATA_W-1:0]  ESP_LIMIT  = 'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  select_1,
    input  logic [SEL_W-1:0]  select_2,
    input  logic              rd_req,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    input  logic              eip_inc,
    input  logic [3:0]        eip_step,
    output logic [OUT_W-1:0]  out_1,
    output logic [OUT_W-1:0]  out_2,
    output logic              out_valid,
    output logic              sel_err,
    output logic              stack_err
);
    localparam int NCODE = 5 + NUM_GPR;
    localparam logic [DATA_W:0] STEP_X   = (DATA_W+1)'(STACK_STEP);
    localparam logic [DATA_W:0] PUSH_MIN = {1'b0, ESP_LIMIT} + STEP_X;

    logic [DATA_W-1:0] eip, ebp, esp;
    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] vals [NCODE];
    logic [DATA_W-1:0] src_1, src_2;
    logic [DATA_W:0]   esp_up;
    logic bad_1, bad_2, bad_wr, wr_esp, wr_ebp, wr_eip;
    logic push_ok, pop_ok, do_push, do_pop;

    always_comb begin
        vals[0] = '0;
        vals[1] = DATA_W'(STACK_STEP);
        vals[2] = esp;
        vals[3] = ebp;
        vals[4] = eip;
        for (int i = 0; i < NUM_GPR; i++) vals[5+i] = gpr[i];
        src_1 = '0;
        src_2 = '0;
        for (int i = 0; i < NCODE; i++) begin
            if (int'(select_1) == i) src_1 = vals[i];
            if (int'(select_2) == i) src_2 = vals[i];
        end
    end

    assign bad_1  = int'(select_1) >= NCODE;
    assign bad_2  = int'(select_2) >= NCODE;
    assign bad_wr = wr_en && (wr_sel < SEL_W'(2) || int'(wr_sel) >= NCODE);
    assign wr_esp = wr_en && wr_sel == SEL_W'(2);
    assign wr_ebp = wr_en && wr_sel == SEL_W'(3);
    assign wr_eip = wr_en && wr_sel == SEL_W'(4);
    // Bounds are compared one bit wider so wrap/carry counts as out of range.
    assign esp_up  = {1'b0, esp} + STEP_X;
    assign push_ok = {1'b0, esp} >= PUSH_MIN;
    assign pop_ok  = esp_up <= {1'b0, ESP_RESET};
    assign do_push = !wr_esp && push && !pop;
    assign do_pop  = !wr_esp && pop && !push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eip       <= '0;
            ebp       <= '0;
            esp       <= ESP_RESET;
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            out_1     <= '0;
            out_2     <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            esp <= wr_esp ? wr_data :
                   (do_push && push_ok) ? esp - DATA_W'(STACK_STEP) :
                   (do_pop && pop_ok) ? esp_up[DATA_W-1:0] : esp;
            eip <= wr_eip ? wr_data : eip_inc ? eip + DATA_W'(eip_step) : eip;
            if (wr_ebp) ebp <= wr_data;
            for (int i = 0; i < NUM_GPR; i++)
                if (wr_en && int'(wr_sel) == 5 + i) gpr[i] <= wr_data;
            out_valid <= rd_req;
            if (rd_req) begin
                out_1 <= OUT_W'(src_1);
                out_2 <= OUT_W'(src_2);
            end
            sel_err   <= sel_err | bad_wr | (rd_req && (bad_1 || bad_2));
            stack_err <= stack_err | (do_push && !push_ok) | (do_pop && !pop_ok);
        end
    end
endmodule

// File: tb/tb_reg_select_bank.sv
// tb_reg_select_bank: directed vectors with hand-computed operands and error flags.
module tb_reg_select_bank;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  select_1, select_2, wr_sel, eip_step;
    logic        rd_req, wr_en, push, pop, eip_inc;
    logic [31:0] wr_data;
    logic [7:0]  out_1, out_2;
    logic        out_valid, sel_err, stack_err;
    int checks = 0;
    int errors = 0;

    reg_select_bank dut (
        .clk(clk), .reset(reset), .select_1(select_1), .select_2(select_2),
        .rd_req(rd_req), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .push(push), .pop(pop), .eip_inc(eip_inc), .eip_step(eip_step),
        .out_1(out_1), .out_2(out_2), .out_valid(out_valid),
        .sel_err(sel_err), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] s1, input logic [3:0] s2);
        select_1 = s1;
        select_2 = s2;
        rd_req = 1;
        tick();
        rd_req = 0;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [31:0] data);
        wr_en = 1;
        wr_sel = sel;
        wr_data = data;
        tick();
        wr_en = 0;
    endtask

    initial begin
        reset = 1;
        {select_1, select_2, wr_sel, eip_step} = '0;
        {rd_req, wr_en, push, pop, eip_inc} = '0;
        wr_data = '0;
        tick();
        tick();
        reset = 0;
        check("rst_out_1", 32'(out_1), 32'h0);
        check("rst_out_2", 32'(out_2), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'h0);
        check("rst_stack_err", 32'(stack_err), 32'h0);

        rd(4'd2, 4'd1);
        check("esp_rst_read", 32'(out_1), 32'h00);
        check("step_read", 32'(out_2), 32'h04);
        check("valid_after_rd", 32'(out_valid), 32'h1);
        tick();
        check("valid_idle", 32'(out_valid), 32'h0);
        check("hold_out_2", 32'(out_2), 32'h04);

        wr_en = 1; wr_sel = 4'd5; wr_data = 32'h1234_56AB;
        rd(4'd5, 4'd0);
        wr_en = 0;
        check("rdw_old", 32'(out_1), 32'h00);
        rd(4'd5, 4'd3);
        check("gpr0_new", 32'(out_1), 32'hAB);
        check("ebp_zero", 32'(out_2), 32'h00);

        push = 1; tick(); tick(); tick(); push = 0;
        rd(4'd2, 4'd0);
        check("push3", 32'(out_1), 32'hF4);
        push = 1; pop = 1; tick(); push = 0; pop = 0;
        rd(4'd2, 4'd0);
        check("push_pop", 32'(out_1), 32'hF4);
        push = 1; wr(4'd2, 32'h80); push = 0;
        rd(4'd2, 4'd0);
        check("wr_over_push", 32'(out_1), 32'h80);
        check("no_stack_err", 32'(stack_err), 32'h0);

        wr(4'd2, 32'h4);
        push = 1; tick();
        push = 0;
        rd(4'd2, 4'd0);
        check("push_to_limit", 32'(out_1), 32'h00);
        check("limit_ok_err", 32'(stack_err), 32'h0);
        push = 1; tick(); push = 0;
        rd(4'd2, 4'd0);
        check("push_rejected", 32'(out_1), 32'h00);
        check("push_err", 32'(stack_err), 32'h1);

        reset = 1; tick(); reset = 0;
        check("err_cleared", 32'(stack_err), 32'h0);
        pop = 1; tick(); pop = 0;
        rd(4'd2, 4'd0);
        check("pop_rejected", 32'(out_1), 32'h00);
        check("pop_err", 32'(stack_err), 32'h1);

        wr(4'd4, 32'hFFFF_FFFE);
        eip_inc = 1; eip_step = 4'd3; tick(); eip_inc = 0;
        rd(4'd4, 4'd0);
        check("eip_wrap", 32'(out_1), 32'h01);
        eip_inc = 1; wr(4'd4, 32'h40); eip_inc = 0;
        rd(4'd4, 4'd0);
        check("eip_wr_prio", 32'(out_1), 32'h40);
        eip_inc = 1; eip_step = 4'd5; tick(); eip_inc = 0;
        check("sel_err_clean", 32'(sel_err), 32'h0);

        rd(4'hF, 4'd4);
        check("bad_sel_zero", 32'(out_1), 32'h00);
        check("eip_inc5", 32'(out_2), 32'h45);
        check("bad_sel_err", 32'(sel_err), 32'h1);

        wr(4'd5, 32'h0000_0077);
        rd(4'd4, 4'd5);
        check("pre_rst_out_1", 32'(out_1), 32'h45);
        check("pre_rst_out_2", 32'(out_2), 32'h77);
        select_1 = 4'd4; rd_req = 1;
        #2 reset = 1;
        #1;
        check("async_out_1", 32'(out_1), 32'h0);
        check("async_out_2", 32'(out_2), 32'h0);
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_sel_err", 32'(sel_err), 32'h0);
        rd_req = 0;
        tick();
        reset = 0;
        wr(4'd1, 32'hDEAD_BEEF);
        check("wr_code1_err", 32'(sel_err), 32'h1);
        rd(4'd1, 4'd5);
        check("code1_unwritten", 32'(out_1), 32'h04);
        check("gpr0_reset", 32'(out_2), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
